// File: rtl/spi_mmio.sv
// Memory-mapped SPI master (mode 0, MSB first) behind a simple processor request port.
//
// Register map (all other addresses miss, rq_hit=0, no response):
//   0x10024018 csmode : bit0 = cs_hold, keeps chip select asserted between bytes
//   0x10024048 txdata : store queues one byte (dropped if busy), load = {tx_full, 31'b0}
//   0x1002404c rxdata : load = {rx_empty, 23'b0, byte}, pops a byte when not empty
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   rq_en/rq_iswrite    request valid / store(1) or load(0), always accepted
//   rq_addr/rq_data     byte address / store data
//   rq_hit              combinational address decode
//   rs_en/rs_data       one-cycle response, one cycle after a hit request
//   spi_sck/spi_cs_n    SPI clock (idle low) / chip select (active low)
//   spi_mosi/spi_miso   serial data out / in
//
// Parameter CLKDIV (1..255): SCK half-period in CLK cycles.
// Build option: define SPI_RXFIFO_EN for a 4-entry receive FIFO (new byte dropped when
// full); otherwise receive is a single byte register that is overwritten on a new byte.

module spi_mmio #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        rq_en,
  input  logic        rq_iswrite,
  input  logic [31:0] rq_addr,
  input  logic [31:0] rq_data,
  output logic        rq_hit,
  output logic        rs_en,
  output logic [31:0] rs_data,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [31:0] AddrCsmode = 32'h1002_4018;
  localparam logic [31:0] AddrTxdata = 32'h1002_4048;
  localparam logic [31:0] AddrRxdata = 32'h1002_404c;
  localparam logic [7:0]  CntMax     = 8'(CLKDIV - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        cs_hold_q, cs_hold_d;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        rs_en_q, rs_en_d;
  logic [31:0] rs_data_q, rs_data_d;

  logic        sel_cs, sel_tx, sel_rx, req;
  logic        tx_accept, rx_pop, rx_push, tx_done, cnt_end;
  logic        rx_empty;
  logic [7:0]  rx_head;
  logic        unused_rq_data;

  assign unused_rq_data = ^rq_data[31:8];

  // Address decode and request qualification
  assign sel_cs    = (rq_addr == AddrCsmode);
  assign sel_tx    = (rq_addr == AddrTxdata);
  assign sel_rx    = (rq_addr == AddrRxdata);
  assign rq_hit    = sel_cs | sel_tx | sel_rx;
  assign req       = rq_en & rq_hit;
  assign tx_accept = req & rq_iswrite & sel_tx & ~tx_full_q;
  assign rx_pop    = req & ~rq_iswrite & sel_rx & ~rx_empty;
  assign cnt_end   = (cnt_q == CntMax);

  // Register file next state and response
  always_comb begin
    cs_hold_d = cs_hold_q;
    tx_full_d = tx_full_q;
    tx_byte_d = tx_byte_q;
    rs_en_d   = req;
    rs_data_d = '0;
    if (req && rq_iswrite && sel_cs) cs_hold_d = rq_data[0];
    if (tx_done) tx_full_d = 1'b0;
    if (tx_accept) begin
      tx_full_d = 1'b1;
      tx_byte_d = rq_data[7:0];
    end
    if (req && !rq_iswrite) begin
      if (sel_cs) begin
        rs_data_d = {31'b0, cs_hold_q};
      end else if (sel_tx) begin
        rs_data_d = {tx_full_q, 31'b0};
      end else begin
        rs_data_d = rx_empty ? 32'h8000_0000 : {24'b0, rx_head};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs_hold_q <= 1'b0;
      tx_full_q <= 1'b0;
      tx_byte_q <= '0;
      rs_en_q   <= 1'b0;
      rs_data_q <= '0;
    end else begin
      cs_hold_q <= cs_hold_d;
      tx_full_q <= tx_full_d;
      tx_byte_q <= tx_byte_d;
      rs_en_q   <= rs_en_d;
      rs_data_q <= rs_data_d;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // FSM next state; bit_cnt counts bits sampled so far (bumped on entry to HIGH)
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (tx_full_q) begin
          state_d   = cs_n_q ? StSetup : StLow;
          bit_cnt_d = '0;
        end
      end
      StSetup: begin
        if (cnt_end) begin
          state_d = StLow;
          cnt_d   = '0;
        end
      end
      StLow: begin
        if (cnt_end) begin
          state_d   = StHigh;
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StHigh: begin
        if (cnt_end) begin
          state_d = (bit_cnt_q < 4'd8) ? StLow : StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: next values of the registered SPI pins and the shifter
  always_comb begin
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    shift_d = shift_q;
    rx_push = 1'b0;
    tx_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (tx_full_q) begin
          shift_d = tx_byte_q;
          cs_n_d  = 1'b0;
          mosi_d  = tx_byte_q[7];
          sck_d   = 1'b0;
        end else if (!cs_n_q && !cs_hold_d) begin
          // Held CS released by software while idle: drop it on the same edge
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
        end
      end
      StLow: begin
        if (cnt_end) begin
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], spi_miso};
        end
      end
      StHigh: begin
        if (cnt_end) begin
          sck_d = 1'b0;
          // After the shift, bit 7 holds the next bit to transmit
          if (bit_cnt_q < 4'd8) mosi_d = shift_q[7];
        end
      end
      StDone: begin
        rx_push = 1'b1;
        tx_done = 1'b1;
        cs_n_d  = ~cs_hold_q;
        if (!cs_hold_q) mosi_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      shift_q <= shift_d;
    end
  end

`ifdef SPI_RXFIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       push_ok;

  assign rx_empty = (count_q == 3'd0);
  assign rx_head  = fifo_q[rd_ptr_q];
  // A simultaneous pop frees a slot, so a push into a full FIFO is kept then
  assign push_ok  = rx_push & ((count_q != 3'd4) | rx_pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !rx_pop) begin
      count_d = count_q + 3'd1;
    end else if (!push_ok && rx_pop) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (rx_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) fifo_q[wr_ptr_q] <= shift_q;
  end
`else
  logic [7:0] rx_byte_q;
  logic       rx_valid_q;

  assign rx_empty = ~rx_valid_q;
  assign rx_head  = rx_byte_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (rx_push) rx_byte_q <= shift_q;
      rx_valid_q <= rx_push | (rx_valid_q & ~rx_pop);
    end
  end
`endif

  assign rs_en    = rs_en_q;
  assign rs_data  = rs_data_q;
  assign spi_sck  = sck_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: doc/spi_mmio.md
SPI_MMIO -- requirements
Module: spi_mmio

Interface
REQ-001 Parameter CLKDIV, default 2, SCK half-period in CLK cycles; legal range 1..255.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 rq_en  input  1  memory request valid from processor request port; always accepted.
REQ-005 rq_iswrite  input  1  1 = store, 0 = load.
REQ-006 rq_addr  input  32  request byte address.
REQ-007 rq_data  input  32  store data.
REQ-008 rq_hit  output  1  combinational; 1 when rq_addr is 0x10024018, 0x10024048 or 0x1002404c.
REQ-009 rs_en  output  1  response valid; consumer always ready.
REQ-010 rs_data  output  32  load data; 0 on store responses.
REQ-011 spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-012 spi_cs_n  output  1  chip select, active-low.
REQ-013 spi_mosi  output  1  master out, MSB first.
REQ-014 spi_miso  input  1  master in.

Function
REQ-015 Response latency: rs_en SHALL assert exactly 1 cycle after a cycle with rq_en && rq_hit, for one cycle per request; no response for non-hit requests.
REQ-016 Register values and side effects SHALL be evaluated on pre-edge state of the request cycle.
REQ-017 0x10024018 csmode: store sets cs_hold = rq_data[0]; load returns {31'b0, cs_hold}.
REQ-018 0x10024048 txdata: load returns {tx_full, 31'b0}; store with tx_full=0 latches rq_data[7:0] and sets tx_full; store with tx_full=1 SHALL be acknowledged and discarded.
REQ-019 tx_full SHALL be 1 from accepted store until the shifter reaches DONE for that byte.
REQ-020 0x1002404c rxdata: load returns {rx_empty, 23'b0, rx_byte}; load with rx_empty=0 pops one byte; load when empty returns 0x80000000 and changes nothing.
REQ-021 FSM states IDLE, SETUP, LOW, HIGH, DONE.
REQ-022 IDLE -> SETUP on tx_full when spi_cs_n=1; IDLE -> LOW on tx_full when spi_cs_n=0 (held).
REQ-023 SETUP: drive spi_cs_n=0 and spi_mosi=bit7, hold CLKDIV cycles, -> LOW.
REQ-024 LOW: spi_sck=0, CLKDIV cycles, -> HIGH; HIGH: spi_sck=1, sample spi_miso into shift LSB on entry, CLKDIV cycles.
REQ-025 HIGH exit: if bit count < 8 shift out next bit on spi_mosi and -> LOW, else -> DONE.
REQ-026 DONE (1 cycle): push received byte to RX, clear tx_full, spi_cs_n <= !cs_hold... i.e. deassert (1) unless cs_hold=1; -> IDLE.
REQ-027 One byte = 16*CLKDIV cycles of SCK activity, plus CLKDIV SETUP cycles when CS was high.
REQ-028 Clearing cs_hold while IDLE with spi_cs_n=0 SHALL deassert spi_cs_n next cycle; during a transfer it takes effect at DONE.
REQ-029 spi_mosi SHALL be 0 whenever spi_cs_n=1.
REQ-030 RX push and rxdata pop in the same cycle: pop returns the older byte, push SHALL not be lost.

Reset
REQ-031 On RST_N low, asynchronously: FSM=IDLE, spi_sck=0, spi_cs_n=1, spi_mosi=0, rs_en=0, rs_data=0, cs_hold=0, tx_full=0, RX empty.
REQ-032 Reset mid-transfer SHALL abort the byte with no RX push; no response is issued for a request in flight.

Configuration
REQ-033 Macro SPI_RXFIFO_EN defined: RX is a 4-entry FIFO; push when full drops the new byte.
REQ-034 SPI_RXFIFO_EN undefined: RX is one byte register plus valid flag; push when valid overwrites the byte.

Verification
REQ-035 CLKDIV=2; store 0xA5 to 0x10024048, MISO loops MOSI -> SETUP 2 cycles, 8 SCK pulses of 4 cycles, MOSI 1,0,1,0,0,1,0,1, then rxdata load returns 0x000000A5.
REQ-036 Store 0x11 then immediately 0x22 to txdata -> only 0x11 shifted; txdata load during transfer returns 0x80000000, after DONE 0x00000000.
REQ-037 Load 0x1002404c with RX empty -> rs_data 0x80000000 one cycle later; load 0x10012000 -> rq_hit=0, no rs_en.
REQ-038 csmode=1, send 0x01 and 0x02 -> spi_cs_n low continuously across both bytes; store csmode=0 while IDLE -> spi_cs_n=1 next cycle.
REQ-039 Pull RST_N low at bit 4 of a transfer -> spi_cs_n=1, spi_sck=0 without clock edge; after release rxdata reads 0x80000000.
REQ-040 Five bytes 0x01..0x05 without reading: with SPI_RXFIFO_EN reads return 0x01..0x04 then 0x80000000; without it one read returns 0x05.
